ps2_key_sequencer: RTL and testbench
====================================

// Module: ps2_key_sequencer
// PURPOSE
//  Converts key events (code, extended flag, press/release) into PS/2 make/break
//  byte sequences ([E0] code, or [E0] F0 code) and feeds them one byte at a time
//  to the PS/2 serializer (start_sending/scan_code in, data_sent back). Sits
//  between the stimulus/event source and the serializer; adds inter-byte gap,
//  typematic auto-repeat of held keys and a lost-handshake watchdog.
// PARAMETERS
//  GAP_CYCLES    16     idle clk cycles after each data_sent before next byte; 0 = none
//  REPEAT_DELAY  50000  clk cycles from make seq_done to first repeat; 0 = repeat off
//  REPEAT_PERIOD 10000  clk cycles between repeats after first (>=1)
//  TIMEOUT       256    max clk cycles start_sending->data_sent (>= 80)
//  All counters 16 bit; every parameter < 65536.
// PORTS
//  clk           in   1  system clock
//  reset         in   1  synchronous, active-high reset
//  key_valid     in   1  key event present
//  key_ready     out  1  event accepted on clk edge where key_valid & key_ready
//  key_code      in   8  scan code byte
//  key_ext       in   1  1 = prefix E0
//  key_release   in   1  1 = break (insert F0), 0 = make
//  scan_code     out  8  byte to serializer
//  start_sending out  1  one-cycle request to serializer
//  data_sent     in   1  one-cycle pulse from serializer at end of byte
//  busy          out  1  sequence in progress (LOAD/WAIT/GAP)
//  seq_done      out  1  one-cycle pulse: full sequence sent
//  timeout_err   out  1  one-cycle pulse: watchdog fired
// BEHAVIOUR
//  Reset: state IDLE; scan_code=0, start_sending=0, busy=0, seq_done=0,
//   timeout_err=0, key_ready=1; event latch, byte index, counters cleared.
//  Reset mid-sequence: abandon immediately; no further start_sending.
//  States: IDLE, LOAD, WAIT_SENT, GAP, HOLD.
//  key_ready = 1 only in IDLE and HOLD. Accept latches code/ext/release, builds
//   byte list (make: [E0],code; break: [E0],F0,code; 1-3 bytes), index=0 -> LOAD.
//  LOAD (1 cycle): scan_code=current byte, start_sending=1 -> WAIT_SENT.
//   start_sending high exactly the cycle after accept/gap end; 0 otherwise.
//  scan_code held stable from LOAD until next LOAD (not cleared at sequence end).
//  WAIT_SENT: count cycles. data_sent -> GAP (GAP_CYCLES=0: straight to next step).
//   data_sent ignored in every other state. Count reaching TIMEOUT w/o data_sent:
//   timeout_err pulse, drop remaining bytes, cancel repeat -> IDLE.
//  GAP: GAP_CYCLES cycles, then: more bytes -> index+1, LOAD; last byte ->
//   seq_done pulse (that cycle), then HOLD if make & REPEAT_DELAY!=0, else IDLE.
//  HOLD: counter loaded REPEAT_DELAY (original make) or REPEAT_PERIOD (repeat).
//   Expiry -> replay same make list from index 0 (LOAD), repeat flag set.
//   key_valid in HOLD is accepted and cancels the repeat; event and expiry on
//   same cycle: event wins, no repeat byte sent.
//  busy=1 in LOAD, WAIT_SENT, GAP; 0 in IDLE, HOLD.
//  Byte order within a sequence is strict; next start_sending never issued
//   before previous data_sent + GAP_CYCLES.
// TESTING  (serializer instance attached, same clk/reset; decode ps2_clk/ps2_dat)
//  1 make 0x1C, ext=0, GAP=4 -> one start pulse, scan_code=0x1C, line bits
//    0,00111000,0(parity),1; seq_done 1 cycle after gap; IDLE, key_ready=1.
//  2 break ext 0x75 -> bytes E0,F0,75 in order; 3 start pulses, each >=4 cycles
//    after prior data_sent; single seq_done after 0x75.
//  3 REPEAT_DELAY=1000, PERIOD=200: make 0x1C -> repeat start 1001 cycles after
//    seq_done, then 201 after each repeat seq_done; break 0x1C -> F0,1C, no repeats.
//  4 data_sent forced 0 -> timeout_err pulse TIMEOUT cycles after start_sending,
//    IDLE, no more starts; next event sends normally.
//  5 reset during byte 2 of break E0 75 -> next edge start_sending=0, busy=0,
//    key_ready=1; following make 0x29 sends cleanly as 0x29.
//  6 key_valid held during sequence -> key_ready=0 until IDLE/HOLD; event and
//    HOLD expiry same cycle -> new event sent, no repeat byte.

Source files
------------

// File: rtl/ps2_key_sequencer_if.sv
// Key-event and serializer handshake bundle for ps2_key_sequencer.
// slave is the sequencer's view; master is the event source plus serializer side.
interface ps2_key_sequencer_if;
   logic       key_valid;
   logic       key_ready;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_release;
   logic [7:0] scan_code;
   logic       start_sending;
   logic       data_sent;
   logic       busy;
   logic       seq_done;
   logic       timeout_err;

   modport master (
      output key_valid, key_code, key_ext, key_release, data_sent,
      input  key_ready, scan_code, start_sending, busy, seq_done, timeout_err
   );

   modport slave (
      input  key_valid, key_code, key_ext, key_release, data_sent,
      output key_ready, scan_code, start_sending, busy, seq_done, timeout_err
   );
endinterface

// File: rtl/ps2_key_sequencer.sv
// Turns key events into PS/2 make/break byte sequences for the serializer,
// with inter-byte gap, typematic auto-repeat and a lost-handshake watchdog.
module ps2_key_sequencer #(
   parameter int unsigned GAP_CYCLES    = 16,
   parameter int unsigned REPEAT_DELAY  = 50000,
   parameter int unsigned REPEAT_PERIOD = 10000,
   parameter int unsigned TIMEOUT       = 256
) (
   input logic                clk,
   input logic                reset,
   ps2_key_sequencer_if.slave bus
);

   localparam logic [15:0] GAP_L     = 16'(GAP_CYCLES);
   localparam logic [15:0] DELAY_L   = 16'(REPEAT_DELAY);
   localparam logic [15:0] PERIOD_L  = 16'(REPEAT_PERIOD);
   localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);
   localparam bit          REPEAT_EN = (REPEAT_DELAY != 0);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_SENT, S_GAP, S_HOLD} state_t;

   state_t      state, state_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic [1:0]  idx_q, idx_nxt;
   logic        repeat_q, repeat_nxt;
   logic [7:0]  code_q;
   logic        ext_q, rel_q;
   logic [7:0]  scan_q;

   logic        accept, load_en, step, last_byte;
   logic [7:0]  load_byte;
   logic        seq_done_c, timeout_c;
   logic [15:0] hold_limit;

   // Byte idx of the list [E0] [F0] code selected by the ext/release flags.
   function automatic logic [7:0] seq_byte(input logic [7:0] code, input logic ext,
                                           input logic rel, input logic [1:0] idx);
      case ({ext, rel})
         2'b01:   seq_byte = (idx == 2'd0) ? 8'hF0 : code;
         2'b10:   seq_byte = (idx == 2'd0) ? 8'hE0 : code;
         2'b11:   seq_byte = (idx == 2'd0) ? 8'hE0 : (idx == 2'd1) ? 8'hF0 : code;
         default: seq_byte = code;
      endcase
   endfunction

   assign last_byte  = (idx_q == ({1'b0, ext_q} + {1'b0, rel_q}));
   assign hold_limit = repeat_q ? PERIOD_L : DELAY_L;

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      state_nxt  = state;
      cnt_nxt    = cnt;
      idx_nxt    = idx_q;
      repeat_nxt = repeat_q;
      accept     = 1'b0;
      load_en    = 1'b0;
      load_byte  = 8'h00;
      step       = 1'b0;
      seq_done_c = 1'b0;
      timeout_c  = 1'b0;

      case (state)
         S_IDLE, S_HOLD: begin
            if (bus.key_valid) begin
               // A new event always beats a repeat expiring on the same cycle.
               accept     = 1'b1;
               state_nxt  = S_LOAD;
               idx_nxt    = 2'd0;
               repeat_nxt = 1'b0;
               load_en    = 1'b1;
               load_byte  = seq_byte(bus.key_code, bus.key_ext, bus.key_release, 2'd0);
            end else if (state == S_HOLD) begin
               if (cnt == hold_limit) begin
                  state_nxt  = S_LOAD;
                  idx_nxt    = 2'd0;
                  repeat_nxt = 1'b1;
                  load_en    = 1'b1;
                  load_byte  = seq_byte(code_q, ext_q, rel_q, 2'd0);
               end else begin
                  cnt_nxt = cnt + 16'd1;
               end
            end
         end
         S_LOAD: begin
            state_nxt = S_WAIT_SENT;
            cnt_nxt   = 16'd1;
         end
         S_WAIT_SENT: begin
            if (bus.data_sent) begin
               if (GAP_L == 16'd0) begin
                  step = 1'b1;
               end else begin
                  state_nxt = S_GAP;
                  cnt_nxt   = 16'd1;
               end
            end else if (cnt == TIMEOUT_L) begin
               timeout_c  = 1'b1;
               state_nxt  = S_IDLE;
               repeat_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         S_GAP: begin
            if (cnt == GAP_L) step = 1'b1;
            else              cnt_nxt = cnt + 16'd1;
         end
         default: state_nxt = S_IDLE;
      endcase

      if (step) begin
         if (!last_byte) begin
            state_nxt = S_LOAD;
            idx_nxt   = idx_q + 2'd1;
            load_en   = 1'b1;
            load_byte = seq_byte(code_q, ext_q, rel_q, idx_q + 2'd1);
         end else begin
            seq_done_c = 1'b1;
            if (!rel_q && REPEAT_EN) begin
               state_nxt = S_HOLD;
               cnt_nxt   = 16'd1;
            end else begin
               state_nxt = S_IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         idx_q    <= '0;
         repeat_q <= 1'b0;
         code_q   <= '0;
         ext_q    <= 1'b0;
         rel_q    <= 1'b0;
         scan_q   <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         idx_q    <= idx_nxt;
         repeat_q <= repeat_nxt;
         if (accept) begin
            code_q <= bus.key_code;
            ext_q  <= bus.key_ext;
            rel_q  <= bus.key_release;
         end
         if (load_en) scan_q <= load_byte;
      end
   end

   assign bus.key_ready     = (state == S_IDLE) || (state == S_HOLD);
   assign bus.start_sending = (state == S_LOAD);
   assign bus.busy          = (state == S_LOAD) || (state == S_WAIT_SENT) || (state == S_GAP);
   assign bus.scan_code     = scan_q;
   assign bus.seq_done      = seq_done_c;
   assign bus.timeout_err   = timeout_c;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Randomized bench for ps2_key_sequencer: a timestamp-based reference model is
// checked against the DUT every cycle, with directed scenarios pinned by literals.
module tb_ps2_key_sequencer;
   localparam int GAP     = 4;
   localparam int RDELAY  = 100;
   localparam int RPERIOD = 30;
   localparam int TMO     = 80;

   logic clk = 1'b0;
   logic reset;
   ps2_key_sequencer_if bus();

   ps2_key_sequencer #(
      .GAP_CYCLES(GAP), .REPEAT_DELAY(RDELAY), .REPEAT_PERIOD(RPERIOD), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: pending bytes plus the cycle stamps that govern them.
   bit         seq_active = 0, hold_active = 0, repeat_mode = 0, cur_make = 0;
   logic [7:0] q[$], make_list[$];
   int         t_issue = 0, t_sent = -1, t_hold_exp = 0;
   logic [7:0] exp_scan = 8'h00;

   // Stimulus controls and observation records.
   bit         kv = 0, kext = 0, krel = 0, rst_req = 0, spur_en = 0;
   logic [7:0] kcode = 8'h00;
   int         ser_mode = 1, ser_lat = 5, ser_due = -1;
   int         accept_cyc = 0, last_start = 0, last_done = 0, last_tmo = 0, last_sent = 0;
   int         start_count = 0, done_count = 0, tmo_count = 0;
   logic [7:0] sent_bytes[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic cycle();
      bit e_start, e_tmo, e_step, e_done, accepted;
      @(negedge clk);
      cyc++;
      reset             = rst_req;
      bus.key_valid     = kv;
      bus.key_code      = kcode;
      bus.key_ext       = kext;
      bus.key_release   = krel;
      bus.data_sent     = (cyc == ser_due) || (spur_en && $urandom_range(0, 39) == 0);
      #1;
      e_start = seq_active && (cyc == t_issue);
      if (e_start) exp_scan = q[0];
      e_tmo = seq_active && (t_sent < 0) && (cyc == t_issue + TMO) && !bus.data_sent;
      if (seq_active && t_sent < 0 && cyc > t_issue && cyc <= t_issue + TMO && bus.data_sent)
         t_sent = cyc;
      e_step = seq_active && (t_sent >= 0) && (cyc == t_sent + GAP);
      e_done = e_step && (q.size() == 1);

      check("key_ready",     32'(bus.key_ready),     32'(!seq_active));
      check("busy",          32'(bus.busy),          32'(seq_active));
      check("start_sending", 32'(bus.start_sending), 32'(e_start));
      check("scan_code",     32'(bus.scan_code),     32'(exp_scan));
      check("seq_done",      32'(bus.seq_done),      32'(e_done));
      check("timeout_err",   32'(bus.timeout_err),   32'(e_tmo));

      if (bus.data_sent) last_sent = cyc;
      if (bus.seq_done)    begin last_done = cyc; done_count++; end
      if (bus.timeout_err) begin last_tmo = cyc;  tmo_count++;  end
      if (bus.start_sending) begin
         last_start = cyc;
         start_count++;
         sent_bytes.push_back(bus.scan_code);
         if (ser_mode == 2 || (ser_mode == 0 && $urandom_range(0, 9) == 0)) ser_due = -1;
         else if (ser_mode == 1) ser_due = cyc + ser_lat;
         else ser_due = cyc + $urandom_range(1, 20);
      end

      accepted = kv && !seq_active && !rst_req;
      if (rst_req) begin
         seq_active  = 0;
         hold_active = 0;
         q.delete();
         exp_scan = 8'h00;
         ser_due  = -1;
      end else begin
         if (e_tmo) begin
            seq_active = 0;
            q.delete();
         end
         if (e_step) begin
            void'(q.pop_front());
            if (q.size() > 0) begin
               t_issue = cyc + 1;
               t_sent  = -1;
            end else begin
               seq_active = 0;
               if (cur_make && RDELAY != 0) begin
                  hold_active = 1;
                  t_hold_exp  = cyc + (repeat_mode ? RPERIOD : RDELAY);
               end
            end
         end
         if (accepted) begin
            q.delete();
            if (kext) q.push_back(8'hE0);
            if (krel) q.push_back(8'hF0);
            q.push_back(kcode);
            cur_make = !krel;
            if (!krel) make_list = q;
            seq_active  = 1;
            hold_active = 0;
            repeat_mode = 0;
            t_issue     = cyc + 1;
            t_sent      = -1;
            accept_cyc  = cyc;
            kv          = 0;
         end else if (hold_active && cyc == t_hold_exp) begin
            q           = make_list;
            seq_active  = 1;
            hold_active = 0;
            repeat_mode = 1;
            t_issue     = cyc + 1;
            t_sent      = -1;
         end
      end
   endtask

   task automatic send_event(input logic [7:0] code, input bit ext, input bit rel);
      kcode = code;
      kext  = ext;
      krel  = rel;
      kv    = 1;
      for (int i = 0; i < 400 && kv; i++) cycle();
      check("event_accepted", 32'(kv), 32'd0);
      kv = 0;
   endtask

   // kind: 0 seq_done, 1 start_sending, 2 timeout_err
   task automatic wait_evt(input int kind, input int budget, input string name);
      int c0;
      bit seen;
      c0   = (kind == 0) ? done_count : (kind == 1) ? start_count : tmo_count;
      seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         cycle();
         seen = ((kind == 0) ? done_count : (kind == 1) ? start_count : tmo_count) != c0;
      end
      check(name, 32'(seen), 32'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      int a, s, st, d0;
      bit found;
      reset = 1'b1;
      bus.key_valid = 0; bus.key_code = 0; bus.key_ext = 0; bus.key_release = 0; bus.data_sent = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Reset state
      cycle();
      check("rst_key_ready", 32'(bus.key_ready), 32'd1);
      check("rst_busy",      32'(bus.busy),      32'd0);
      check("rst_scan",      32'(bus.scan_code), 32'h00);

      // Make 0x1C: single byte, seq_done GAP cycles after data_sent
      ser_mode = 1; ser_lat = 5;
      sent_bytes.delete();
      send_event(8'h1C, 0, 0);
      a = accept_cyc;
      wait_evt(0, 100, "d1_done_seen");
      check("d1_start_lat", 32'(last_start - a), 32'd1);
      check("d1_nbytes",    32'(sent_bytes.size()), 32'd1);
      check("d1_byte",      32'(sent_bytes[0]), 32'h1C);
      check("d1_done_lat",  32'(last_done - a), 32'd10);
      check("d1_gap",       32'(last_done - last_sent), 32'd4);

      // Typematic repeat of the held make
      s = last_done;
      wait_evt(1, 300, "rep1_seen");
      check("rep_first_delay", 32'(last_start - s), 32'd101);
      check("rep_byte", 32'(sent_bytes[sent_bytes.size() - 1]), 32'h1C);
      wait_evt(0, 100, "rep1_done_seen");
      s = last_done;
      wait_evt(1, 300, "rep2_seen");
      check("rep_period", 32'(last_start - s), 32'd31);
      wait_evt(0, 100, "rep2_done_seen");

      // Break 0x1C: F0,1C and no repeats afterwards
      sent_bytes.delete();
      send_event(8'h1C, 0, 1);
      wait_evt(0, 100, "brk_done_seen");
      st = start_count;
      idle(200);
      check("brk_no_repeat", 32'(start_count - st), 32'd0);
      check("brk_nbytes", 32'(sent_bytes.size()), 32'd2);
      check("brk_bytes",  32'({sent_bytes[0], sent_bytes[1]}), 32'hF01C);

      // Extended break 0x75: E0,F0,75 with gaps, one seq_done
      sent_bytes.delete();
      d0 = done_count;
      send_event(8'h75, 1, 1);
      a = accept_cyc;
      wait_evt(0, 200, "ext_done_seen");
      idle(20);
      check("ext_nbytes",   32'(sent_bytes.size()), 32'd3);
      check("ext_bytes",    32'({sent_bytes[0], sent_bytes[1], sent_bytes[2]}), 32'hE0F075);
      check("ext_done_lat", 32'(last_done - a), 32'd30);
      check("ext_one_done", 32'(done_count - d0), 32'd1);

      // Lost handshake: watchdog, then a clean send
      ser_mode = 2;
      st = start_count;
      send_event(8'h29, 0, 0);
      wait_evt(2, 200, "tmo_seen");
      check("tmo_latency", 32'(last_tmo - last_start), 32'd80);
      idle(50);
      check("tmo_no_more_starts", 32'(start_count - st), 32'd1);
      ser_mode = 1;
      sent_bytes.delete();
      send_event(8'h15, 0, 0);
      wait_evt(0, 100, "post_tmo_done_seen");
      check("post_tmo_byte", 32'(sent_bytes[0]), 32'h15);

      // Reset during the second byte of break E0 75
      st = start_count;
      send_event(8'h75, 1, 1);
      wait_evt(1, 100, "rst_b1_seen");
      wait_evt(1, 100, "rst_b2_seen");
      idle(2);
      rst_req = 1;
      cycle();
      rst_req = 0;
      cycle();
      check("rst_mid_start", 32'(bus.start_sending), 32'd0);
      check("rst_mid_busy",  32'(bus.busy),          32'd0);
      check("rst_mid_ready", 32'(bus.key_ready),     32'd1);
      sent_bytes.delete();
      send_event(8'h29, 0, 0);
      wait_evt(0, 100, "rst_after_done_seen");
      check("rst_after_nbytes", 32'(sent_bytes.size()), 32'd1);
      check("rst_after_byte",   32'(sent_bytes[0]), 32'h29);

      // key_valid held through a sequence, then event colliding with repeat expiry
      send_event(8'h1C, 0, 0);
      kcode = 8'h5A; kext = 0; krel = 0; kv = 1;
      idle(3);
      check("held_key_ready", 32'(bus.key_ready), 32'd0);
      check("held_busy",      32'(bus.busy),      32'd1);
      wait_evt(0, 100, "held_first_done_seen");
      s = last_done;
      cycle();
      check("held_accept_in_hold", 32'(accept_cyc - s), 32'd1);
      wait_evt(0, 100, "held_second_done_seen");
      s = last_done;
      sent_bytes.delete();
      found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (hold_active && cyc + 1 == t_hold_exp) begin
            kcode = 8'h33; kext = 0; krel = 0; kv = 1;
            found = 1;
         end
         cycle();
      end
      check("collide_reached", 32'(found), 32'd1);
      check("collide_accept_at_expiry", 32'(accept_cyc - s), 32'd100);
      kv = 0;
      wait_evt(0, 100, "collide_done_seen");
      check("collide_first_byte", 32'(sent_bytes[0]), 32'h33);

      // Randomized traffic with spurious handshakes, drops and resets
      ser_mode = 0;
      spur_en  = 1;
      for (int i = 0; i < 15000; i++) begin
         if (!kv && $urandom_range(0, 299) == 0) begin
            kcode = 8'($urandom);
            kext  = 1'($urandom_range(0, 1));
            krel  = ($urandom_range(0, 2) == 0);
            kv    = 1;
         end
         rst_req = seq_active && ($urandom_range(0, 499) == 0);
         cycle();
         sent_bytes.delete();
      end
      rst_req = 0;
      spur_en = 0;
      kv      = 0;
      idle(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
